// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared widths, reset config and helpers for the programmable clock divider
package clk_div_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int N_CH_DEF = 4;
  localparam int DEF_DIV_DEF = 2;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int CH_W = ch_w(N_CH_DEF);
  typedef struct packed {
    logic [CNT_W_DEF-1:0] div;
    logic [CNT_W_DEF-1:0] high;
  } div_cfg_t;
  localparam div_cfg_t RST_CFG = '{div: CNT_W_DEF'(DEF_DIV_DEF), high: CNT_W_DEF'(DEF_DIV_DEF / 2)};
endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel with shadowed config and registered outputs
module clk_div_channel import clk_div_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             CLK_IN,
  input  logic             nRST,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_high,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);
  logic [CNT_W-1:0] cnt, act_div, act_high, sh_div, sh_high;
  logic bnd, restart;
  // a zero divisor parks the channel, so every cycle counts as a period boundary
  always_comb begin
    bnd = (act_div == '0) ? 1'b1 : (cnt >= act_div - CNT_W'(1));
    restart = ~en | sync | bnd;
  end
  // counter, registered outputs and shadow-to-active config transfer
  always_ff @(posedge CLK_IN) begin
    if (!nRST) begin
      cnt <= '0;
      act_div <= CNT_W'(DEF_DIV);
      act_high <= CNT_W'(DEF_DIV / 2);
      sh_div <= CNT_W'(DEF_DIV);
      sh_high <= CNT_W'(DEF_DIV / 2);
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick <= 1'b0;
    end else begin
      cnt <= restart ? '0 : cnt + CNT_W'(1);
      clk_out <= en && act_div != '0 && cnt < act_high;
      tick <= en && act_div != '0 && cnt == '0;
      if (wr && sync) begin
        act_div <= wr_div;
        act_high <= wr_high;
        pending <= 1'b0;
      end else if (wr) begin
        sh_div <= wr_div;
        sh_high <= wr_high;
        pending <= 1'b1;
      end else if (pending && restart) begin
        act_div <= sh_div;
        act_high <= sh_high;
        pending <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/prog_clk_div.sv
// prog_clk_div: multi-channel programmable divided-clock and tick generator
module prog_clk_div import clk_div_pkg::*; #(
  parameter int N_CH = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF,
  localparam int SEL_W = ch_w(N_CH)
) (
  input  logic             CLK_IN,
  input  logic             nRST,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             sync_all,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SEL_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);
  logic [N_CH-1:0] sel, pending, wr;
  // one-hot channel select; an out-of-range channel selects nothing and is always ready
  always_comb begin
    for (int i = 0; i < N_CH; i++) sel[i] = cfg_ch == SEL_W'(i);
    cfg_ready = ~|(sel & pending);
    wr = sel & {N_CH{cfg_valid & cfg_ready}};
  end
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    clk_div_channel #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_ch (
      .CLK_IN(CLK_IN),
      .nRST(nRST),
      .en(ch_en[c]),
      .sync(sync_all),
      .wr(wr[c]),
      .wr_div(cfg_div),
      .wr_high(cfg_high),
      .pending(pending[c]),
      .clk_out(clk_out[c]),
      .tick(tick[c])
    );
  end
endmodule

// File: tb/tb_prog_clk_div.sv
// tb_prog_clk_div: scoreboard bench with a period-position reference model
module tb_prog_clk_div;
  localparam int N_CH = 4;
  localparam int CNT_W = 16;
  localparam int DEF_DIV = 2;
  localparam int CH_W = 2;
  logic CLK_IN = 1'b0;
  logic nRST = 1'b0;
  logic [N_CH-1:0] ch_en = '0;
  logic sync_all = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [CH_W-1:0] cfg_ch = '0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic [CNT_W-1:0] cfg_high = '0;
  logic [N_CH-1:0] clk_out, tick;
  int checks = 0;
  int errors = 0;
  logic q_rdy[$];
  logic [2*N_CH-1:0] q_out[$];
  int m_div[N_CH], m_high[N_CH], m_sdiv[N_CH], m_shigh[N_CH], m_pos[N_CH];
  bit m_pend[N_CH];
  logic [N_CH-1:0] cur_en;

  prog_clk_div #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .CLK_IN(CLK_IN), .nRST(nRST), .ch_en(ch_en), .sync_all(sync_all),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .clk_out(clk_out), .tick(tick)
  );

  initial forever #5 CLK_IN = ~CLK_IN;

  task automatic cyc(input bit r, input logic [N_CH-1:0] e, input bit s, input bit v,
                     input int c, input int d, input int h);
    bit rdy, x, wrap;
    logic [N_CH-1:0] ck, tk;
    @(negedge CLK_IN);
    nRST = r; ch_en = e; sync_all = s; cfg_valid = v;
    cfg_ch = CH_W'(c); cfg_div = CNT_W'(d); cfg_high = CNT_W'(h);
    rdy = (c >= N_CH) ? 1'b1 : !m_pend[c];
    q_rdy.push_back(rdy);
    x = v && rdy;
    ck = '0; tk = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!r) begin
        m_div[i] = DEF_DIV; m_high[i] = DEF_DIV / 2; m_pend[i] = 0; m_pos[i] = 0;
        continue;
      end
      ck[i] = e[i] && m_div[i] != 0 && m_pos[i] < m_high[i];
      tk[i] = e[i] && m_div[i] != 0 && m_pos[i] == 0;
      wrap = (m_div[i] == 0) ? 1'b1 : ((m_pos[i] + 1) % m_div[i] == 0);
      m_pos[i] = (!e[i] || s || wrap) ? 0 : m_pos[i] + 1;
      if (x && c == i && s) begin
        m_div[i] = d; m_high[i] = h; m_pend[i] = 0;
      end else if (x && c == i) begin
        m_sdiv[i] = d; m_shigh[i] = h; m_pend[i] = 1;
      end else if (m_pend[i] && (!e[i] || s || wrap)) begin
        m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; m_pend[i] = 0;
      end
    end
    q_out.push_back({ck, tk});
  endtask

  task automatic idle(input int n, input logic [N_CH-1:0] e);
    for (int k = 0; k < n; k++) cyc(1, e, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [N_CH-1:0] e, input int c, input int d, input int h);
    cyc(1, e, 0, 1, c, d, h);
  endtask

  initial begin : mon_rdy
    logic exp;
    forever begin
      @(negedge CLK_IN);
      #2;
      if (q_rdy.size() != 0) begin
        exp = q_rdy.pop_front();
        checks++;
        if (cfg_ready !== exp) begin
          errors++;
          $display("FAIL cfg_ready t=%0t got %b expected %b", $time, cfg_ready, exp);
        end
      end
    end
  end

  initial begin : mon_out
    logic [2*N_CH-1:0] exp;
    forever begin
      @(posedge CLK_IN);
      #1;
      if (q_out.size() != 0) begin
        exp = q_out.pop_front();
        checks++;
        if ({clk_out, tick} !== exp) begin
          errors++;
          $display("FAIL clk_out/tick t=%0t got %b/%b expected %b/%b",
                   $time, clk_out, tick, exp[2*N_CH-1:N_CH], exp[N_CH-1:0]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) cyc(0, '1, 0, 0, 0, 0, 0);
    idle(10, '1);
    wr('1, 0, 5, 2);
    idle(15, '1);
    wr('1, 0, 6, 3);
    wr('1, 0, 3, 1);
    wr('1, 1, 7, 4);
    idle(20, '1);
    wr('1, 2, 0, 0);
    wr('1, 3, 1, 1);
    wr('1, 1, 4, 7);
    idle(20, '1);
    wr('1, 0, 3, 1);
    wr('1, 1, 4, 2);
    wr('1, 2, 6, 3);
    idle(13, '1);
    cyc(1, '1, 1, 0, 0, 0, 0);
    idle(15, '1);
    cyc(1, '1, 1, 1, 3, 5, 2);
    idle(8, '1);
    idle(4, 4'b0101);
    idle(6, '1);
    wr('1, 0, 7, 3);
    idle(2, '1);
    cyc(0, '1, 0, 0, 0, 0, 0);
    cyc(0, '1, 0, 1, 1, 9, 4);
    idle(10, '1);
    cur_en = '1;
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 39) == 0) cur_en[$urandom_range(0, N_CH-1)] ^= 1'b1;
      cyc($urandom_range(0, 299) != 0, cur_en, $urandom_range(0, 49) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, N_CH-1),
          $urandom_range(0, 9), $urandom_range(0, 10));
    end
    repeat (3) @(negedge CLK_IN);
    if (q_out.size() != 0 || q_rdy.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain left %0d/%0d entries expected 0/0", q_out.size(), q_rdy.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
